// File: rtl/lsu_region_decoder.sv
// LSU address decoder: base/mask region select with per-region strobes, load data
// steering through a read-latency pipeline, and sticky fault capture.
module lsu_region_decoder #(
  parameter int                        NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h1001_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_MASK = {3{32'hFFFF_0000}},
  parameter int                        RD_LATENCY  = 1,
  parameter int                        DATA_W      = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [31:0]                   i_lsu_addr,
  input  logic                          i_lsu_wren,
  input  logic                          i_lsu_rden,
  input  logic [1:0]                    i_lsu_size,
  output logic [NUM_REGIONS-1:0]        o_region_valid,
  output logic [NUM_REGIONS-1:0]        o_region_wren,
  input  logic [NUM_REGIONS*DATA_W-1:0] i_region_rdata,
  output logic [DATA_W-1:0]             o_lsu_rdata,
  output logic                          o_lsu_rvalid,
  input  logic                          i_fault_clr,
  output logic                          o_fault,
  output logic [31:0]                   o_fault_addr,
  output logic [15:0]                   o_fault_cnt
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      2'b10:   return |lsb;
      default: return 1'b1;
    endcase
  endfunction

  logic                   req;
  logic                   hit;
  logic                   misaligned;
  logic                   fault;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_REGIONS-1:0] win;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if ((i_lsu_addr & REGION_MASK[k*32 +: 32]) ==
          (REGION_BASE[k*32 +: 32] & REGION_MASK[k*32 +: 32])) begin
        hit     = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    req        = i_lsu_wren | i_lsu_rden;
    misaligned = is_misaligned(i_lsu_size, i_lsu_addr[1:0]);
    fault      = req & (~hit | misaligned);
    for (int k = 0; k < NUM_REGIONS; k++) begin
      win[k]            = hit && (win_idx == IDX_W'(k));
      o_region_valid[k] = req & win[k] & ~misaligned;
      o_region_wren[k]  = req & win[k] & ~misaligned & i_lsu_wren;
    end
  end

  logic [RD_LATENCY-1:0]            vld_d, vld_q;
  logic [RD_LATENCY-1:0]            zero_d, zero_q;
  logic [RD_LATENCY-1:0][IDX_W-1:0] idx_d, idx_q;

  always_comb begin
    vld_d[0]  = i_lsu_rden & ~i_lsu_wren;
    zero_d[0] = fault;
    idx_d[0]  = win_idx;
    for (int s = 1; s < RD_LATENCY; s++) begin
      vld_d[s]  = vld_q[s-1];
      zero_d[s] = zero_q[s-1];
      idx_d[s]  = idx_q[s-1];
    end
  end

  // Load tracking pipeline: only valid bits are reset, so in-flight loads vanish.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    zero_q <= zero_d;
    idx_q  <= idx_d;
  end

  always_comb begin
    o_lsu_rvalid = vld_q[RD_LATENCY-1];
    o_lsu_rdata  = '0;
    if (vld_q[RD_LATENCY-1] && !zero_q[RD_LATENCY-1]) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        if (idx_q[RD_LATENCY-1] == IDX_W'(k)) begin
          o_lsu_rdata = i_region_rdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  logic        fault_d, fault_q;
  logic [31:0] fault_addr_d, fault_addr_q;
  logic [15:0] fault_cnt_d, fault_cnt_q;

  // A fault arriving with a clear restarts the record from that fault.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_cnt_d  = fault_cnt_q;
    if (fault) begin
      if (!fault_q || i_fault_clr) begin
        fault_d      = 1'b1;
        fault_addr_d = i_lsu_addr;
      end
      fault_cnt_d = i_fault_clr ? 16'd1 : sat_inc(fault_cnt_q);
    end else if (i_fault_clr) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
      fault_cnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;
  assign o_fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_lsu_region_decoder.sv
// Randomized scoreboard bench for lsu_region_decoder, run on a latency-1 and a
// latency-3 instance sharing the same stimulus.
module tb_lsu_region_decoder;
  localparam int NR = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, wren = 1'b0, rden = 1'b0, clr = 1'b0;
  logic [31:0]       addr = '0;
  logic [1:0]        size = '0;
  logic [NR*DW-1:0]  region_rdata = '0;
  logic [NR-1:0]     v1, w1, v3, w3;
  logic [DW-1:0]     rd1, rd3;
  logic              rv1, rv3, f1, f3;
  logic [31:0]       fa1, fa3;
  logic [15:0]       fc1, fc3;

  lsu_region_decoder #(.RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_lsu_wren(wren), .i_lsu_rden(rden),
    .i_lsu_size(size), .o_region_valid(v1), .o_region_wren(w1), .i_region_rdata(region_rdata),
    .o_lsu_rdata(rd1), .o_lsu_rvalid(rv1), .i_fault_clr(clr), .o_fault(f1),
    .o_fault_addr(fa1), .o_fault_cnt(fc1));

  lsu_region_decoder #(.RD_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_lsu_wren(wren), .i_lsu_rden(rden),
    .i_lsu_size(size), .o_region_valid(v3), .o_region_wren(w3), .i_region_rdata(region_rdata),
    .o_lsu_rdata(rd3), .o_lsu_rvalid(rv3), .i_fault_clr(clr), .o_fault(f3),
    .o_fault_addr(fa3), .o_fault_cnt(fc3));

  typedef struct {
    int due;
    int idx;
    bit zero;
  } ld_t;

  ld_t         q[2][$];
  logic [31:0] base_t[NR];
  logic [31:0] mask_t[NR];
  logic [31:0] rdata_arr[NR];
  int          edge_cnt = 0;
  bit          mon_en = 1'b0;
  bit          hold_rdata = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          m_flt = 1'b0, n_flt;
  logic [31:0] m_addr = '0, n_addr;
  logic [15:0] m_cnt = '0, n_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic check_pipe(input int p, input logic rv, input logic [DW-1:0] rd);
    ld_t e;
    if (rv) begin
      if (q[p].size() == 0) begin
        chk($sformatf("rvalid_unexpected_%0d", p), 1, 0);
      end else begin
        e = q[p].pop_front();
        chk($sformatf("rvalid_edge_%0d", p), 64'(edge_cnt), 64'(e.due));
        chk($sformatf("rdata_%0d", p), rd, e.zero ? 32'h0 : rdata_arr[e.idx]);
      end
    end else begin
      if (q[p].size() > 0 && q[p][0].due <= edge_cnt) begin
        e = q[p].pop_front();
        chk($sformatf("rvalid_missing_%0d", p), 0, 1);
      end
      chk($sformatf("rdata_idle_%0d", p), rd, 0);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic w, input logic r,
                      input logic [1:0] sz, input logic c, input logic rs);
    int            hit;
    bit            mis, flt;
    logic [NR-1:0] ev, ew;
    ld_t           e;
    ld_t           keep[$];
    addr = a; wren = w; rden = r; size = sz; clr = c; rst = rs;
    if (!hold_rdata) for (int i = 0; i < NR; i++) rdata_arr[i] = $urandom;
    for (int i = 0; i < NR; i++) region_rdata[i*DW +: DW] = rdata_arr[i];

    hit = -1;
    for (int k = 0; k < NR; k++)
      if (hit < 0 && ((a ^ base_t[k]) & mask_t[k]) == 32'h0) hit = k;
    mis = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    flt = (w || r) && (hit < 0 || mis);
    ev  = '0;
    if ((w || r) && !flt) ev[hit] = 1'b1;
    ew  = w ? ev : '0;

    n_flt = m_flt; n_addr = m_addr; n_cnt = m_cnt;
    if (rs) begin
      n_flt = 1'b0; n_addr = '0; n_cnt = '0;
    end else if (flt) begin
      if (!m_flt || c) begin
        n_flt = 1'b1; n_addr = a;
      end
      n_cnt = c ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
    end else if (c) begin
      n_flt = 1'b0; n_addr = '0; n_cnt = '0;
    end

    for (int p = 0; p < 2; p++) begin
      if (rs) begin
        keep = {};
        for (int j = 0; j < q[p].size(); j++)
          if (q[p][j].due < edge_cnt + 1) keep.push_back(q[p][j]);
        q[p] = keep;
      end else if (r && !w) begin
        e.due  = edge_cnt + ((p == 0) ? 1 : 3);
        e.idx  = flt ? 0 : hit;
        e.zero = flt;
        q[p].push_back(e);
      end
    end

    @(negedge clk);
    if (!rs) begin
      chk("region_valid_1", v1, ev);
      chk("region_wren_1", w1, ew);
      chk("region_valid_3", v3, ev);
      chk("region_wren_3", w3, ew);
    end
    @(posedge clk);
    edge_cnt++;
    m_flt = n_flt; m_addr = n_addr; m_cnt = n_cnt;
    if (rs) mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_pipe(0, rv1, rd1);
        check_pipe(1, rv3, rd3);
        chk("fault_1", f1, m_flt);
        chk("fault_addr_1", fa1, m_addr);
        chk("fault_cnt_1", fc1, m_cnt);
        chk("fault_3", f3, m_flt);
        chk("fault_addr_3", fa3, m_addr);
        chk("fault_cnt_3", fc3, m_cnt);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          pick;
    base_t = '{32'h0000_0000, 32'h1000_0000, 32'h1001_0000};
    mask_t = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    @(posedge clk);
    #1;
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    idle(2);

    // Word load to region 0 with fixed read data
    hold_rdata = 1'b1;
    rdata_arr  = '{32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222};
    step(32'h0000_0100, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idle(3);
    hold_rdata = 1'b0;

    // Store to region 1 then load from region 2
    step(32'h1000_0004, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    step(32'h1001_0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idle(3);

    // Unmapped load
    step(32'h2000_0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idle(3);

    // Misaligned half store then misaligned word load after a clear
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step(32'h0000_0003, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    step(32'h0000_0006, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idle(3);

    // Drive the counter into saturation, then clear together with a new fault
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) step(32'h2000_0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("cnt_saturated", 64'(m_cnt), 64'hFFFF);
    step(32'h3000_0000, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    idle(3);

    // Back-to-back loads across regions, then reset with loads in flight
    step(32'h0000_0100, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step(32'h1000_0008, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step(32'h1001_000C, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step(32'h0000_0200, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    idle(4);

    for (int i = 0; i < 1500; i++) begin
      pick = $urandom_range(0, 4);
      if (pick < 3)       a = base_t[pick] | ($urandom & 32'h0000_FFFF);
      else if (pick == 3) a = $urandom;
      else                a = 32'h2000_0000 | ($urandom & 32'h0000_00FF);
      step(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    end
    idle(5);

    chk("queue_drained_1", 64'(q[0].size()), 0);
    chk("queue_drained_3", 64'(q[1].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
